// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches the decoded control word and operands for EX,
// resolves the destination register, and stalls/bubbles on load-use hazards.
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  id_reg_dst,
  input  logic                  id_alu_src,
  input  logic                  id_memto_reg,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_branch,
  input  logic [ALUOP_W-1:0]    id_alu_op,
  input  logic [DATA_W-1:0]     id_pc_plus4,
  input  logic [DATA_W-1:0]     id_rd1,
  input  logic [DATA_W-1:0]     id_rd2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [5:0]            id_funct,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  ex_valid,
  output logic                  ex_reg_dst,
  output logic                  ex_alu_src,
  output logic                  ex_memto_reg,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic [DATA_W-1:0]     ex_pc_plus4,
  output logic [DATA_W-1:0]     ex_rd1,
  output logic [DATA_W-1:0]     ex_rd2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [5:0]            ex_funct,
  output logic [REG_ADDR_W-1:0] ex_write_reg
);

  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic               memto_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  ctrl_t                 ctrl_id, ctrl_d, ctrl_q;
  logic                  valid_d, valid_q;
  logic                  uses_rt, hazard;
  logic [DATA_W-1:0]     pc_plus4_q, rd1_q, rd2_q, imm_q;
  logic [REG_ADDR_W-1:0] rs_q, rt_q, write_reg_d, write_reg_q;
  logic [5:0]            funct_q;

  assign ctrl_id = '{reg_dst: id_reg_dst, alu_src: id_alu_src, memto_reg: id_memto_reg,
                     reg_write: id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write,
                     branch: id_branch, alu_op: id_alu_op};

  // A load in EX blocks any ID instruction that reads its target; $0 never carries a dependency.
  assign uses_rt = id_reg_dst | id_mem_write | id_branch;
  assign hazard  = valid_q & ctrl_q.mem_read & id_valid & (rt_q != '0) &
                   ((rt_q == id_rs) | (uses_rt & (rt_q == id_rt)));
  assign stall_o = hazard & ~flush_i;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    valid_d     = id_valid;
    ctrl_d      = id_valid ? ctrl_id : '0;
    write_reg_d = id_reg_dst ? id_rd : id_rt;
    if (flush_i || stall_o) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      pc_plus4_q  <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      funct_q     <= '0;
      write_reg_q <= '0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      pc_plus4_q  <= id_pc_plus4;
      rd1_q       <= id_rd1;
      rd2_q       <= id_rd2;
      imm_q       <= id_imm;
      rs_q        <= id_rs;
      rt_q        <= id_rt;
      funct_q     <= id_funct;
      write_reg_q <= write_reg_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_reg_dst   = ctrl_q.reg_dst;
  assign ex_alu_src   = ctrl_q.alu_src;
  assign ex_memto_reg = ctrl_q.memto_reg;
  assign ex_reg_write = ctrl_q.reg_write;
  assign ex_mem_read  = ctrl_q.mem_read;
  assign ex_mem_write = ctrl_q.mem_write;
  assign ex_branch    = ctrl_q.branch;
  assign ex_alu_op    = ctrl_q.alu_op;
  assign ex_pc_plus4  = pc_plus4_q;
  assign ex_rd1       = rd1_q;
  assign ex_rd2       = rd2_q;
  assign ex_imm       = imm_q;
  assign ex_rs        = rs_q;
  assign ex_rt        = rt_q;
  assign ex_funct     = funct_q;
  assign ex_write_reg = write_reg_q;

endmodule
